// File: rtl/status_ctrl.sv
// status_ctrl: program status register with same-cycle flag forwarding,
// registered branch-condition evaluation and an interrupt status stack.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   res, carry, upd_en  writeback ALU result/carry and flag-update strobe
//   br_req, br_cond     branch-condition request and condition select
//   br_valid, br_taken  registered branch result (1-cycle latency)
//   int_req, rti_req    push status (interrupt entry) / pop status (return)
//   err_clr             clears the sticky stack error
//   status              registered program status {C, NZ, Z, ~LSB, PARITY}
//   stk_full/stk_empty  stack occupancy decoded from the stack pointer
//   stk_err             sticky overflow/underflow flag
module status_ctrl #(
    parameter int STK_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] res,
    input  logic        carry,
    input  logic        upd_en,
    input  logic        br_req,
    input  logic [2:0]  br_cond,
    input  logic        int_req,
    input  logic        rti_req,
    input  logic        err_clr,
    output logic [4:0]  status,
    output logic        br_valid,
    output logic        br_taken,
    output logic        stk_full,
    output logic        stk_empty,
    output logic        stk_err
);

    // sp counts 0..STK_DEPTH, so it needs one more code than the index.
    localparam int SPW = $clog2(STK_DEPTH + 1);
    localparam int IW  = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
    localparam logic [SPW-1:0] SP_MAX = SPW'(STK_DEPTH);

    logic [4:0]     status_q, status_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic           br_valid_q, br_valid_d;
    logic           br_taken_q, br_taken_d;
    logic           err_q, err_d;
    logic [4:0]     stk_q [STK_DEPTH];

    logic [4:0]     nf, ef;
    logic           cond_hit;
    logic           push, pop, full_w, empty_w;
    logic           stk_we;
    logic [SPW-1:0] sp_dec;
    logic [IW-1:0]  wr_idx, rd_idx;

    // Fresh flags from writeback; ef forwards them so a branch or push in
    // the same cycle sees the update before it lands in status.
    assign nf = {carry, |res, ~|res, ~res[0], ^res};
    assign ef = upd_en ? nf : status_q;

    always_comb begin
        cond_hit = 1'b0;
        unique case (br_cond)
            3'b000: cond_hit = 1'b1;
            3'b001: cond_hit = ef[2];
            3'b010: cond_hit = ef[3];
            3'b011: cond_hit = ef[4];
            3'b100: cond_hit = ~ef[4];
            3'b101: cond_hit = ef[0];
            3'b110: cond_hit = ef[1];
            3'b111: cond_hit = 1'b0;
            default: cond_hit = 1'b0;
        endcase
    end

    // Simultaneous int/rti: the push wins and the pop is dropped silently.
    assign push    = int_req;
    assign pop     = rti_req & ~int_req;
    assign full_w  = (sp_q == SP_MAX);
    assign empty_w = (sp_q == '0);
    assign sp_dec  = sp_q - SPW'(1);
    assign wr_idx  = sp_q[IW-1:0];
    assign rd_idx  = sp_dec[IW-1:0];
    assign stk_we  = push & ~full_w;

    always_comb begin
        status_d   = status_q;
        sp_d       = sp_q;
        err_d      = err_q;
        br_valid_d = br_req;
        br_taken_d = br_req & cond_hit;

        if (upd_en) begin
            status_d = nf;
        end

        if (push) begin
            if (!full_w) begin
                sp_d = sp_q + SPW'(1);
            end else begin
                err_d = 1'b1;
            end
        end else if (pop) begin
            if (!empty_w) begin
                // Restored status overrides any writeback update.
                sp_d     = sp_dec;
                status_d = stk_q[rd_idx];
            end else begin
                err_d = 1'b1;
            end
        end

        // A new error on the same edge as err_clr keeps the flag set.
        if (err_clr && !((push && full_w) || (pop && empty_w))) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status_q   <= '0;
            sp_q       <= '0;
            br_valid_q <= 1'b0;
            br_taken_q <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < STK_DEPTH; i++) begin
                stk_q[i] <= '0;
            end
        end else begin
            status_q   <= status_d;
            sp_q       <= sp_d;
            br_valid_q <= br_valid_d;
            br_taken_q <= br_taken_d;
            err_q      <= err_d;
            if (stk_we) begin
                stk_q[wr_idx] <= ef;
            end
        end
    end

    assign status    = status_q;
    assign br_valid  = br_valid_q;
    assign br_taken  = br_taken_q;
    assign stk_full  = full_w;
    assign stk_empty = empty_w;
    assign stk_err   = err_q;

endmodule

// File: tb/tb_status_ctrl.sv
module tb_status_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] res = '0;
    logic        carry = 1'b0;
    logic        upd_en = 1'b0;
    logic        br_req = 1'b0;
    logic [2:0]  br_cond = '0;
    logic        int_req = 1'b0;
    logic        rti_req = 1'b0;
    logic        err_clr = 1'b0;
    logic [4:0]  status;
    logic        br_valid, br_taken, stk_full, stk_empty, stk_err;

    int vecs = 0;
    int errs = 0;

    status_ctrl #(.STK_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .res(res), .carry(carry),
        .upd_en(upd_en), .br_req(br_req), .br_cond(br_cond),
        .int_req(int_req), .rti_req(rti_req), .err_clr(err_clr),
        .status(status), .br_valid(br_valid), .br_taken(br_taken),
        .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        upd_en = 0; res = '0; carry = 0; br_req = 0; br_cond = '0;
        int_req = 0; rti_req = 0; err_clr = 0;
    endtask

    initial begin
        // Reset state
        #1;
        chk5("rst_status", status, 5'b00000);
        chk1("rst_empty", stk_empty, 1'b1);
        chk1("rst_full", stk_full, 1'b0);
        chk1("rst_brv", br_valid, 1'b0);
        chk1("rst_err", stk_err, 1'b0);
        @(negedge clk);
        reset_n = 1;

        // res=0 carry=0 -> 00110
        upd_en = 1; res = 32'h0; carry = 0;
        tick();
        chk5("upd_zero", status, 5'b00110);
        chk1("upd_zero_brv", br_valid, 1'b0);

        // Forwarded carry drives cond 011 in the same cycle
        upd_en = 1; res = 32'h1; carry = 1; br_req = 1; br_cond = 3'b011;
        tick();
        chk1("fwd_brv", br_valid, 1'b1);
        chk1("fwd_brt", br_taken, 1'b1);
        chk5("fwd_status", status, 5'b11001);

        // Back-to-back branches against status 11001
        idle(); br_req = 1; br_cond = 3'b100;
        tick();
        chk1("b2b0_brv", br_valid, 1'b1);
        chk1("b2b0_brt", br_taken, 1'b0);
        br_cond = 3'b101;
        tick();
        chk1("b2b1_brt", br_taken, 1'b1);
        br_cond = 3'b111;
        tick();
        chk1("never_brv", br_valid, 1'b1);
        chk1("never_brt", br_taken, 1'b0);
        br_cond = 3'b010;
        tick();
        chk1("nz_brt", br_taken, 1'b1);
        br_req = 0;
        tick();
        chk1("nobr_brv", br_valid, 1'b0);
        chk1("nobr_brt", br_taken, 1'b0);

        // Zero flag forwarded: cond 001 with res=0; cond 110 next cycle
        upd_en = 1; res = 32'h0; br_req = 1; br_cond = 3'b001;
        tick();
        chk1("z_brt", br_taken, 1'b1);
        chk5("z_status", status, 5'b00110);
        idle(); br_req = 1; br_cond = 3'b110;
        tick();
        chk1("lsb_brt", br_taken, 1'b1);
        idle();

        // Fill the stack; 5th push overflows
        int_req = 1;
        tick(); tick(); tick();
        chk1("push3_full", stk_full, 1'b0);
        chk1("push3_empty", stk_empty, 1'b0);
        tick();
        chk1("push4_full", stk_full, 1'b1);
        chk1("push4_err", stk_err, 1'b0);
        tick();
        chk1("ovf_err", stk_err, 1'b1);
        chk1("ovf_full", stk_full, 1'b1);
        chk5("ovf_status", status, 5'b00110);
        // Drain: four pops leave the stack empty (so sp stayed at 4)
        int_req = 0; rti_req = 1;
        tick(); tick(); tick();
        chk1("pop3_empty", stk_empty, 1'b0);
        tick();
        chk1("pop4_empty", stk_empty, 1'b1);
        chk5("pop4_status", status, 5'b00110);
        chk1("pop4_err", stk_err, 1'b1);
        idle(); err_clr = 1;
        tick();
        chk1("clr_err", stk_err, 1'b0);
        idle();

        // Pop overrides upd_en
        upd_en = 1; res = 32'h1; carry = 1;
        tick();
        idle(); int_req = 1;
        tick();
        idle(); upd_en = 1; res = 32'h0;
        tick();
        chk5("pre_pop_status", status, 5'b00110);
        rti_req = 1;
        tick();
        chk5("pop_wins", status, 5'b11001);
        chk1("pop_wins_empty", stk_empty, 1'b1);
        chk1("pop_wins_err", stk_err, 1'b0);

        // Underflow with err_clr on the same edge keeps err set
        idle(); rti_req = 1; err_clr = 1;
        tick();
        chk1("unf_err", stk_err, 1'b1);
        chk5("unf_status", status, 5'b11001);
        idle(); err_clr = 1;
        tick();
        chk1("unf_clr", stk_err, 1'b0);
        // Underflow still applies upd_en
        idle(); rti_req = 1; upd_en = 1; res = 32'h0;
        tick();
        chk5("unf_upd_status", status, 5'b00110);
        chk1("unf_upd_err", stk_err, 1'b1);
        idle(); err_clr = 1;
        tick();

        // int+rti together: push wins, stores forwarded 11001, no error
        idle(); int_req = 1; rti_req = 1; upd_en = 1; res = 32'h1; carry = 1;
        tick();
        chk1("both_empty", stk_empty, 1'b0);
        chk1("both_err", stk_err, 1'b0);
        chk5("both_status", status, 5'b11001);
        idle(); upd_en = 1; res = 32'h0;
        tick();
        idle(); rti_req = 1;
        tick();
        chk5("fwd_push_restore", status, 5'b11001);
        chk1("fwd_push_empty", stk_empty, 1'b1);

        // Reset mid-operation with a branch result pending
        idle(); int_req = 1;
        tick();
        br_req = 1; br_cond = 3'b000;
        tick();
        chk1("pre_rst_brv", br_valid, 1'b1);
        #2;
        reset_n = 0;
        #1;
        chk5("arst_status", status, 5'b00000);
        chk1("arst_empty", stk_empty, 1'b1);
        chk1("arst_brv", br_valid, 1'b0);
        chk1("arst_brt", br_taken, 1'b0);
        chk1("arst_err", stk_err, 1'b0);
        idle();
        @(negedge clk);
        reset_n = 1;
        rti_req = 1;
        tick();
        chk1("post_rst_unf", stk_err, 1'b1);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
